// File: rtl/fft_reorder_256_pkg.sv
// Shared constants and helpers for the 256-point FFT output reorder block.
package fft_reorder_256_pkg;

  localparam int DATA_W = 24;
  localparam int N      = 256;
  localparam int LOG2N  = 8;

  // Mirror the 8 address bits: bit b of the result is bit 7-b of the input.
  function automatic logic [LOG2N-1:0] bitrev8(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = a[LOG2N-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_256_if.sv
// Sample stream into the reorder block and reordered stream out of it.
//
// Handshake: there is no ready. in_valid qualifies din_r/din_i for exactly the
// rising edge that follows; the block always accepts. out_valid qualifies
// dout_r/dout_i/out_index/out_last for the current cycle; the sink must accept.
interface fft_reorder_256_if #(
  parameter int DATA_W = fft_reorder_256_pkg::DATA_W,
  parameter int LOG2N  = fft_reorder_256_pkg::LOG2N
);

  logic                     in_valid;
  logic signed [DATA_W-1:0] din_r;
  logic signed [DATA_W-1:0] din_i;
  logic                     out_valid;
  logic signed [DATA_W-1:0] dout_r;
  logic signed [DATA_W-1:0] dout_i;
  logic [LOG2N-1:0]         out_index;
  logic                     out_last;

  // Producer of FFT samples / consumer of reordered samples.
  modport master (
    output in_valid, din_r, din_i,
    input  out_valid, dout_r, dout_i, out_index, out_last
  );

  // The reorder block itself.
  modport slave (
    input  in_valid, din_r, din_i,
    output out_valid, dout_r, dout_i, out_index, out_last
  );

endinterface

// File: rtl/fft_reorder_256_bank_ram.sv
// One ping-pong bank: simple dual-port RAM, one write port, one registered
// read port. The read register holds its value when re is low and is the only
// part with a reset; the array itself keeps its contents through reset.
module reorder_bank_ram
  import fft_reorder_256_pkg::*;
#(
  parameter int WIDTH = 2 * DATA_W,
  parameter int DEPTH = N,
  parameter int AW    = LOG2N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the sample at its scattered address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: register the addressed word, hold it while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fft_reorder_256.sv
// Converts a bit-reversed FFT output stream into natural bin order.
// Samples are scattered into one bank at bitrev8(arrival count) while the
// other, completed bank is swept linearly 0..255, one word per cycle.
module fft_reorder_256 #(
  parameter int DATA_W = fft_reorder_256_pkg::DATA_W,
  parameter int N      = fft_reorder_256_pkg::N
) (
  input  logic               clk,
  input  logic               rst_n,
  fft_reorder_256_if.slave   bus
);

  import fft_reorder_256_pkg::LOG2N;
  import fft_reorder_256_pkg::bitrev8;

  localparam int AW = LOG2N;
  localparam int W  = 2 * DATA_W;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  // Write side
  logic [AW-1:0] wr_cnt;
  logic          wr_sel;      // bank currently being filled
  logic          frame_done;  // this edge stores the 256th sample of a frame

  // Read side
  logic          rd_active;   // a read of rd_bank at rd_addr happens this edge
  logic [AW-1:0] rd_addr;
  logic          rd_bank;
  logic          out_sel;     // bank whose read register drives dout

  logic [1:0]    bank_we;
  logic [1:0]    bank_re;
  logic [W-1:0]  bank_rdata [2];

  assign frame_done = bus.in_valid && (wr_cnt == LAST_ADDR);

  assign bank_we[0] = bus.in_valid && !wr_sel;
  assign bank_we[1] = bus.in_valid &&  wr_sel;
  assign bank_re[0] = rd_active && !rd_bank;
  assign bank_re[1] = rd_active &&  rd_bank;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    reorder_bank_ram #(
      .WIDTH (W),
      .DEPTH (N),
      .AW    (AW)
    ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (bank_we[b]),
      .waddr (bitrev8(wr_cnt)),
      .wdata ({bus.din_r, bus.din_i}),
      .re    (bank_re[b]),
      .raddr (rd_addr),
      .rdata (bank_rdata[b])
    );
  end

  // Count accepted samples; flip to the other bank when a frame completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      wr_sel <= 1'b0;
    end else if (bus.in_valid) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (frame_done) begin
        wr_sel <= ~wr_sel;
      end
    end
  end

  // Sweep the completed bank; a new completion restarts the sweep at 0 even
  // on the edge that reads address 255, so back-to-back frames have no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_active <= 1'b0;
      rd_addr   <= '0;
      rd_bank   <= 1'b0;
    end else if (frame_done) begin
      rd_active <= 1'b1;
      rd_addr   <= '0;
      rd_bank   <= wr_sel;
    end else if (rd_active) begin
      if (rd_addr == LAST_ADDR) begin
        rd_active <= 1'b0;
      end
      rd_addr <= rd_addr + 1'b1;
    end
  end

  // Output qualifiers line up with the RAM read register; index holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_index <= '0;
      out_sel       <= 1'b0;
    end else begin
      bus.out_valid <= rd_active;
      bus.out_last  <= rd_active && (rd_addr == LAST_ADDR);
      if (rd_active) begin
        bus.out_index <= rd_addr;
        out_sel       <= rd_bank;
      end
    end
  end

  assign bus.dout_r = out_sel ? bank_rdata[1][W-1:DATA_W] : bank_rdata[0][W-1:DATA_W];
  assign bus.dout_i = out_sel ? bank_rdata[1][DATA_W-1:0] : bank_rdata[0][DATA_W-1:0];

endmodule

// File: tb/tb_fft_reorder_256.sv
// Bench for fft_reorder_256: random and directed frames against a frame-level
// reference model that predicts every output cycle.
module tb_fft_reorder_256;

  localparam int DW = 24;
  localparam int EW = 8 + 2 * DW;

  logic clk;
  logic rst_n;

  fft_reorder_256_if bus ();

  fft_reorder_256 #(.DATA_W(DW), .N(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  int checks;
  int failures;
  int cyc;
  logic [EW-1:0] exp_q[$];
  int            due_q[$];
  logic signed [DW-1:0] m_r [256];
  logic signed [DW-1:0] m_i [256];
  int m_wr_cnt;
  logic signed [DW-1:0] last_r, last_i;
  logic [7:0] last_idx;

  // Observations
  int valid_count, last_count, run, max_run, first_valid_cyc, complete_cyc;
  logic signed [DW-1:0] obs_r [256];
  logic signed [DW-1:0] obs_i [256];

  function automatic int rev(input int a);
    int v, r;
    v = a;
    r = 0;
    repeat (8) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: every negedge, check the outputs of the edge just passed,
  // then feed the model the inputs that the next edge will capture.
  task automatic compare_loop();
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        due_q.delete();
        m_wr_cnt = 0;
        last_r = '0;
        last_i = '0;
        last_idx = '0;
        run = 0;
        check("reset_out", {bus.out_valid, bus.out_last, bus.out_index, bus.dout_r, bus.dout_i}, 64'd0);
      end else begin
        if (bus.out_valid) begin
          valid_count++;
          run++;
          if (run > max_run) max_run = run;
          if (bus.out_last) last_count++;
          obs_r[bus.out_index] = bus.dout_r;
          obs_i[bus.out_index] = bus.dout_i;
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end else begin
          run = 0;
        end
        if (due_q.size() > 0 && due_q[0] == cyc) begin
          e = exp_q.pop_front();
          void'(due_q.pop_front());
          check("frame_out",
                {bus.out_valid, bus.out_last, bus.out_index, bus.dout_r, bus.dout_i},
                {1'b1, (e[EW-1:2*DW] == 8'd255), e});
          last_idx = e[EW-1:2*DW];
          last_r   = e[2*DW-1:DW];
          last_i   = e[DW-1:0];
        end else begin
          check("idle_hold",
                {bus.out_valid, bus.out_last, bus.out_index, bus.dout_r, bus.dout_i},
                {1'b0, 1'b0, last_idx, last_r, last_i});
        end
        if (bus.in_valid) begin
          m_r[m_wr_cnt] = bus.din_r;
          m_i[m_wr_cnt] = bus.din_i;
          if (m_wr_cnt == 255) begin
            // Bin n is the sample that arrived rev(n)-th; frame done next edge.
            complete_cyc = cyc + 1;
            for (int n = 0; n < 256; n++) begin
              exp_q.push_back({8'(n), m_r[rev(n)], m_i[rev(n)]});
              due_q.push_back(cyc + 2 + n);
            end
          end
          m_wr_cnt = (m_wr_cnt + 1) % 256;
        end
      end
    end
  endtask

  // Driver tasks
  task automatic send(input logic signed [DW-1:0] r, input logic signed [DW-1:0] i);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b1;
    bus.din_r = r;
    bus.din_i = i;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic clear_stats();
    valid_count = 0;
    last_count = 0;
    max_run = 0;
    first_valid_cyc = -1;
  endtask

  task automatic async_reset_check(input string name);
    #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check(name, {bus.out_valid, bus.out_last, bus.out_index, bus.dout_r, bus.dout_i}, 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    bit found;
    checks = 0;
    failures = 0;
    cyc = 0;
    m_wr_cnt = 0;
    last_r = '0;
    last_i = '0;
    last_idx = '0;
    run = 0;
    complete_cyc = -1;
    clear_stats();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.din_r = '0;
    bus.din_i = '0;
    fork
      compare_loop();
    join_none
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Model pins
    check("rev_1", 64'(rev(1)), 64'd128);
    check("rev_6", 64'(rev(6)), 64'd96);

    // Continuous frame: bin k carried as (k, -k)
    clear_stats();
    for (int j = 0; j < 256; j++) send(DW'(rev(j)), -DW'(rev(j)));
    idle(262);
    check("a_latency", 64'(first_valid_cyc), 64'(complete_cyc + 1));
    check("a_valid_cnt", 64'(valid_count), 64'd256);
    check("a_last_cnt", 64'(last_count), 64'd1);
    check("a_run", 64'(max_run), 64'd256);
    check("a_r0", 64'(obs_r[0]), 64'd0);
    check("a_r1", 64'(obs_r[1]), 64'd1);
    check("a_r128", 64'(obs_r[128]), 64'd128);
    check("a_i255", 64'(obs_i[255]), 64'(-255));
    check("a_i37", 64'(obs_i[37]), 64'(-37));

    // Three back-to-back random frames
    clear_stats();
    for (int j = 0; j < 768; j++) send(DW'($urandom), DW'($urandom));
    idle(262);
    check("b_valid_cnt", 64'(valid_count), 64'd768);
    check("b_run", 64'(max_run), 64'd768);
    check("b_last_cnt", 64'(last_count), 64'd3);

    // Gapped input: alternate valid/idle
    clear_stats();
    for (int j = 0; j < 256; j++) begin
      send(DW'(rev(j)), -DW'(rev(j)));
      idle(1);
    end
    idle(262);
    check("c_valid_cnt", 64'(valid_count), 64'd256);
    check("c_latency", 64'(first_valid_cyc), 64'(complete_cyc + 1));
    check("c_r200", 64'(obs_r[200]), 64'd200);

    // Random gap lengths
    clear_stats();
    for (int j = 0; j < 256; j++) begin
      send(DW'($urandom), DW'($urandom));
      idle($urandom_range(0, 3));
    end
    idle(262);
    check("r_valid_cnt", 64'(valid_count), 64'd256);

    // Reset after 100 samples of a frame: partial frame discarded
    for (int j = 0; j < 100; j++) send(DW'($urandom), DW'($urandom));
    @(posedge clk);
    #1;
    async_reset_check("d_async_zero");
    clear_stats();
    for (int j = 0; j < 255; j++) send(DW'($urandom), DW'($urandom));
    idle(5);
    check("d_no_early_valid", 64'(valid_count), 64'd0);
    send(DW'($urandom), DW'($urandom));
    idle(262);
    check("d_valid_cnt", 64'(valid_count), 64'd256);

    // Extremes at every bin
    clear_stats();
    for (int j = 0; j < 256; j++) send(24'sh800000, 24'sh7FFFFF);
    idle(262);
    check("e_r7", 64'(obs_r[7]), 64'(-8388608));
    check("e_i250", 64'(obs_i[250]), 64'd8388607);
    check("e_valid_cnt", 64'(valid_count), 64'd256);

    // Reset during a read at out_index 128
    for (int j = 0; j < 256; j++) send(DW'($urandom), DW'($urandom));
    idle(1);
    found = 1'b0;
    for (int t = 0; t < 400 && !found; t++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_index == 8'd128) found = 1'b1;
    end
    check("g_reached_128", 64'(found), 64'd1);
    async_reset_check("g_async_zero");
    clear_stats();
    idle(300);
    check("g_no_tail", 64'(valid_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
